// File: rtl/ysyx_23060061_ifu_pkg.sv
// ysyx_23060061_ifu_pkg: shared FSM encodings and constants for the fetch unit.
package ysyx_23060061_ifu_pkg;
  typedef enum logic [2:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_RESP,
    IFU_ISSUE,
    IFU_WAIT_NPC,
    IFU_HALT
  } ifu_state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_23060061_pc_reg.sv
// ysyx_23060061_pc_reg: loadable PC register, async active-low reset to RESET_PC.
module ysyx_23060061_pc_reg #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_o <= RESET_PC;
    else if (load_i) q_o <= d_i;
endmodule

// File: rtl/ysyx_23060061_ifu.sv
// ysyx_23060061_ifu: single-issue fetch unit, one AR/R read per instruction,
// valid/ready hand-off to decode, then waits for the next PC.
module ysyx_23060061_ifu
  import ysyx_23060061_ifu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic [XLEN-1:0] npc,
  input  logic            npc_valid,
  output logic            fault,
  output logic [31:0]     fetch_cnt
);
  ifu_state_e      state_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;
  logic            fault_q;
  logic [31:0]     cnt_q;
  logic            npc_ok;
  logic            pc_load;
  assign npc_ok  = npc[1:0] == 2'b00;
  // npc is only taken together with (or after) the decode hand-off
  assign pc_load = npc_valid && npc_ok &&
                   ((state_q == IFU_ISSUE && inst_ready) || state_q == IFU_WAIT_NPC);
  ysyx_23060061_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(pc_load),
    .d_i   (npc),
    .q_o   (pc_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IFU_IDLE;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IFU_IDLE: state_q <= IFU_REQ;
        IFU_REQ:  if (arready) state_q <= IFU_RESP;
        IFU_RESP:
          if (rvalid) begin
            if (rresp == RESP_OKAY) begin
              inst_q  <= rdata;
              state_q <= IFU_ISSUE;
            end else begin
              fault_q <= 1'b1;
              state_q <= IFU_HALT;
            end
          end
        IFU_ISSUE:
          if (inst_ready) begin
            cnt_q   <= cnt_q + 32'd1;
            state_q <= !npc_valid ? IFU_WAIT_NPC : npc_ok ? IFU_REQ : IFU_HALT;
            if (npc_valid && !npc_ok) fault_q <= 1'b1;
          end
        IFU_WAIT_NPC:
          if (npc_valid) begin
            state_q <= npc_ok ? IFU_REQ : IFU_HALT;
            if (!npc_ok) fault_q <= 1'b1;
          end
        default: state_q <= IFU_HALT;
      endcase
    end
  assign araddr     = pc_q;
  assign arvalid    = state_q == IFU_REQ;
  assign rready     = state_q == IFU_RESP;
  assign inst_valid = state_q == IFU_ISSUE;
  assign inst       = inst_q;
  assign inst_pc    = pc_q;
  assign fault      = fault_q;
  assign fetch_cnt  = cnt_q;
endmodule
